// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, bit-timer width, frame sizing
// and the baud count values that the baud decoder also uses.
package uart_pkg;

    // Width of the bit-time count delivered by the baud decoder.
    localparam int K_WIDTH = 19;

    // Longest frame after the start bit: 8 data + parity + stop.
    localparam int MAX_FRAME_BITS = 10;

    // Receiver FSM encoding, kept as plain constants for older tools.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Bit-time counts for a 100 MHz system clock.
    localparam logic [K_WIDTH-1:0] K_230400 = 19'd434;
    localparam logic [K_WIDTH-1:0] K_115200 = 19'd868;
    localparam logic [K_WIDTH-1:0] K_57600  = 19'd1736;
    localparam logic [K_WIDTH-1:0] K_38400  = 19'd2604;
    localparam logic [K_WIDTH-1:0] K_19200  = 19'd5208;
    localparam logic [K_WIDTH-1:0] K_9600   = 19'd10417;
    localparam logic [K_WIDTH-1:0] K_4800   = 19'd20833;
    localparam logic [K_WIDTH-1:0] K_2400   = 19'd41667;
    localparam logic [K_WIDTH-1:0] K_1200   = 19'd83333;
    localparam logic [K_WIDTH-1:0] K_600    = 19'd166667;
    localparam logic [K_WIDTH-1:0] K_300    = 19'd333333;

    // Line configuration captured at the start of each frame so that
    // host writes during a frame cannot disturb it.
    typedef struct packed {
        logic [K_WIDTH-1:0] k;
        logic               eight;
        logic               pen;
        logic               ohel;
    } rx_cfg_t;

    // Number of bits sampled between the start bit and the stop bit:
    // 7 or 8 data bits plus an optional parity bit.
    function automatic logic [3:0] payload_bits(input logic eight,
                                                input logic pen);
        return 4'd7 + {3'b000, eight} + {3'b000, pen};
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer shared by the UART receiver and transmitter. It counts
// clk cycles up from zero and pulses tick for one cycle when the count
// reaches target-1, where target is a full bit time k or half of it.
module uart_bit_timer
    import uart_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               half_sel,
    input  logic [K_WIDTH-1:0] k,
    output logic               tick
);

    localparam logic [K_WIDTH-1:0] ONE = {{(K_WIDTH-1){1'b0}}, 1'b1};

    logic [K_WIDTH-1:0] count;
    logic [K_WIDTH-1:0] target;

    // Pick the half-bit interval (to reach mid start bit) or a full bit.
    always_comb begin
        target = half_sel ? (k >> 1) : k;
    end

    assign tick = ~clear & (count == (target - ONE));

    // Free-running count that wraps to zero on every tick; clear holds it at zero.
    always_ff @(posedge clk) begin
        if (reset || clear || tick) begin
            count <= '0;
        end else begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART serial receiver. Synchronises rx, finds the start bit, samples
// every following bit at mid-bit time and hands the finished character
// to the host with ready, parity, framing and overrun status.
module uart_rx
    import uart_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_LEVEL  = 1'b1
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               rx,
    input  logic [K_WIDTH-1:0] k,
    input  logic               eight,
    input  logic               pen,
    input  logic               ohel,
    input  logic               clr_rxrdy,
    output logic [7:0]         rx_data,
    output logic               rxrdy,
    output logic               perr,
    output logic               ferr,
    output logic               ovf
);

    logic [SYNC_STAGES-1:0]    sync_q;
    logic                      rxs;
    logic [1:0]                state;
    rx_cfg_t                   cfg;
    logic [3:0]                bit_cnt;
    logic [MAX_FRAME_BITS-1:0] shift_q;
    logic                      wait_high;

    logic                      tick;
    logic                      timer_clear;
    logic                      half_sel;
    logic                      line_active;
    logic [3:0]                payload_n;
    logic [3:0]                align_shift;
    logic [MAX_FRAME_BITS-1:0] aligned;
    logic [7:0]                char_data;
    logic                      parity_bad;
    logic                      stop_bad;
    logic                      done;

    // Metastability synchroniser; it idles at the line idle level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    // The timer sits at zero while idle, so T0 is the first counted cycle.
    assign timer_clear = (state == ST_IDLE);
    assign half_sel    = (state == ST_START);

    uart_bit_timer u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear),
        .half_sel (half_sel),
        .k        (cfg.k),
        .tick     (tick)
    );

    // Derive the finished character and its status from the shift register.
    always_comb begin
        line_active = (rxs != IDLE_LEVEL);
        payload_n   = payload_bits(cfg.eight, cfg.pen);
        align_shift = 4'(MAX_FRAME_BITS) - payload_n;
        aligned     = shift_q >> align_shift;
        char_data   = cfg.eight ? aligned[7:0] : {1'b0, aligned[6:0]};
        parity_bad  = cfg.pen & ((^aligned) != cfg.ohel);
        stop_bad    = line_active;
        done        = (state == ST_STOP) & tick;
    end

    // Frame sequencing: start detect, start-bit check, data shift, stop sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cfg       <= '0;
            bit_cnt   <= '0;
            shift_q   <= '0;
            wait_high <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wait_high) begin
                        if (!line_active) begin
                            wait_high <= 1'b0;
                        end
                    end else if (line_active) begin
                        cfg.k     <= k;
                        cfg.eight <= eight;
                        cfg.pen   <= pen;
                        cfg.ohel  <= ohel;
                        bit_cnt   <= '0;
                        shift_q   <= '0;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state <= line_active ? ST_DATA : ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shift_q <= {rxs, shift_q[MAX_FRAME_BITS-1:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        if ((bit_cnt + 4'd1) == payload_n) begin
                            state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        state     <= ST_IDLE;
                        wait_high <= line_active;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Host-visible status; a completing frame takes priority over a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data <= '0;
            rxrdy   <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            ovf     <= 1'b0;
        end else if (done) begin
            rx_data <= char_data;
            rxrdy   <= 1'b1;
            perr    <= parity_bad;
            ferr    <= stop_bad;
            ovf     <= rxrdy & ~clr_rxrdy;
        end else if (clr_rxrdy) begin
            rxrdy   <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            ovf     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: drives serial frames bit by bit and compares the
// host-side outputs against a frame-level model of the receiver.
module tb_uart_rx;
    import uart_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              rx;
    logic [K_WIDTH-1:0] k;
    logic              eight;
    logic              pen;
    logic              ohel;
    logic              clr_rxrdy;
    logic [7:0]        rx_data;
    logic              rxrdy;
    logic              perr;
    logic              ferr;
    logic              ovf;

    int n_checks = 0;
    int n_fails  = 0;

    logic       m_rxrdy;
    logic       m_perr;
    logic       m_ferr;
    logic       m_ovf;
    logic [7:0] m_data;

    uart_rx #(
        .SYNC_STAGES (2),
        .IDLE_LEVEL  (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .k         (k),
        .eight     (eight),
        .pen       (pen),
        .ohel      (ohel),
        .clr_rxrdy (clr_rxrdy),
        .rx_data   (rx_data),
        .rxrdy     (rxrdy),
        .perr      (perr),
        .ferr      (ferr),
        .ovf       (ovf)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkStatus(input string tag);
        checkOutput({tag, ".rxrdy"},   32'(rxrdy),   32'(m_rxrdy));
        checkOutput({tag, ".rx_data"}, 32'(rx_data), 32'(m_data));
        checkOutput({tag, ".perr"},    32'(perr),    32'(m_perr));
        checkOutput({tag, ".ferr"},    32'(ferr),    32'(m_ferr));
        checkOutput({tag, ".ovf"},     32'(ovf),     32'(m_ovf));
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic clrPulse();
        clr_rxrdy = 1'b1;
        tick1();
        clr_rxrdy = 1'b0;
        m_rxrdy = 1'b0;
        m_perr  = 1'b0;
        m_ferr  = 1'b0;
        m_ovf   = 1'b0;
        checkStatus("clr");
    endtask

    // Sends one frame; the character appears one cycle after the stop-bit
    // sample, 3 + k/2 + n*k edges after the start bit is driven (two
    // synchroniser edges plus the detection edge).
    task automatic applyStimulus(input logic [7:0] data, input int kk,
                                 input logic e, input logic p, input logic o,
                                 input logic bad_par, input logic stop_val,
                                 input logic clr_at_tc, input int reset_at,
                                 input logic mess_cfg, input string tag);
        logic [7:0] masked;
        logic       par;
        logic       bits[$];
        logic       aborted;
        int         nd;
        int         n;
        int         tc;
        int         total;

        k     = K_WIDTH'(kk);
        eight = e;
        pen   = p;
        ohel  = o;

        masked = e ? data : {1'b0, data[6:0]};
        nd     = e ? 8 : 7;
        par    = (($countones(masked) % 2) == 1) ^ o ^ bad_par;

        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < nd; i++) bits.push_back(masked[i]);
        if (p) bits.push_back(par);
        bits.push_back(stop_val);

        n       = bits.size() - 1;
        tc      = 3 + (kk / 2) + n * kk;
        total   = (n + 1) * kk + 6;
        aborted = 1'b0;

        for (int t = 0; t < total; t++) begin
            if (aborted || (t / kk) > n) rx = 1'b1;
            else                         rx = bits[t / kk];

            if (mess_cfg && t == 2 * kk) begin
                k     = K_WIDTH'(kk * 2 + 3);
                eight = ~e;
                pen   = ~p;
                ohel  = ~o;
            end

            if (reset_at >= 0 && t == reset_at) begin
                reset   = 1'b1;
                aborted = 1'b1;
            end else if (reset_at >= 0 && t == reset_at + 1) begin
                reset   = 1'b0;
                m_rxrdy = 1'b0;
                m_perr  = 1'b0;
                m_ferr  = 1'b0;
                m_ovf   = 1'b0;
                m_data  = 8'h00;
                checkStatus({tag, ".after_reset"});
            end

            if (!aborted && t == tc - 1) begin
                checkOutput({tag, ".rxrdy_before"}, 32'(rxrdy), 32'(m_rxrdy));
                checkOutput({tag, ".data_held"}, 32'(rx_data), 32'(m_data));
                if (clr_at_tc) clr_rxrdy = 1'b1;
            end

            if (!aborted && t == tc) begin
                clr_rxrdy = 1'b0;
                m_ovf   = m_rxrdy & ~clr_at_tc;
                m_rxrdy = 1'b1;
                m_data  = masked;
                m_perr  = p & bad_par;
                m_ferr  = ~stop_val;
                checkStatus(tag);
            end

            tick1();
        end
    endtask

    // Short low pulse that must be rejected at the mid-start-bit sample.
    task automatic applyGlitch(input int kk, input int low_len, input int span);
        k = K_WIDTH'(kk);
        for (int t = 0; t < span; t++) begin
            rx = (t < low_len) ? 1'b0 : 1'b1;
            tick1();
        end
        checkOutput("glitch.rxrdy", 32'(rxrdy), 32'(m_rxrdy));
        checkOutput("glitch.rx_data", 32'(rx_data), 32'(m_data));
    endtask

    // Directed scenarios followed by randomized frames.
    initial begin
        reset     = 1'b1;
        rx        = 1'b1;
        k         = K_115200;
        eight     = 1'b1;
        pen       = 1'b0;
        ohel      = 1'b0;
        clr_rxrdy = 1'b0;
        m_rxrdy   = 1'b0;
        m_perr    = 1'b0;
        m_ferr    = 1'b0;
        m_ovf     = 1'b0;
        m_data    = 8'h00;

        repeat (3) tick1();
        checkStatus("reset");
        reset = 1'b0;
        repeat (4) tick1();

        $display("[TB] basic 8N1 frame at k=868");
        applyStimulus(8'hA5, 868, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0, "a5");

        $display("[TB] even parity, wrong then right");
        clrPulse();
        applyStimulus(8'h03, 868, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b0, "par_bad");
        clrPulse();
        applyStimulus(8'h03, 868, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0, "par_ok");

        $display("[TB] 7-bit odd parity, then low stop bit");
        clrPulse();
        applyStimulus(8'h7F, 109, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1, 1'b0, "odd7");
        clrPulse();
        applyStimulus(8'h7F, 109, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b0, "stop_low");

        $display("[TB] start glitch then valid frame");
        clrPulse();
        applyGlitch(868, 200, 3 + 868 / 2 + 3);
        applyStimulus(8'h5A, 868, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0, "after_glitch");

        $display("[TB] overrun and coincident clear");
        clrPulse();
        applyStimulus(8'h11, 109, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0, "ovr1");
        applyStimulus(8'h22, 109, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0, "ovr2");
        clrPulse();
        applyStimulus(8'h44, 109, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0, "pre_coinc");
        applyStimulus(8'h55, 109, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0, "coinc");

        $display("[TB] reset during data bit 4");
        applyStimulus(8'hC3, 868, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                      5 * 868 + 434, 1'b0, "abort");
        applyStimulus(8'h96, 109, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0, "post_reset");

        $display("[TB] configuration changed mid-frame");
        applyStimulus(8'h3C, 109, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b1, "cfg_change");

        $display("[TB] randomized frames");
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 1) clrPulse();
            applyStimulus(8'($urandom),
                          int'($urandom_range(16, 80)),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 3) == 0),
                          -1, 1'b0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
